// File: rtl/mux_pkg.sv
// Shared constants for the registered M:1 multiplexer and its round-robin arbiter.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = ~MODE_FIXED;

    // Reset contents of the output register
    localparam logic        OUT_DATA_RST_BIT = 1'b0;
    localparam int unsigned OUT_CHANNEL_RST  = 0;

endpackage

// File: rtl/rr_arbiter_M.sv
// Round-robin request arbiter: scans last+1 .. last (mod M) and grants the first active request.
module rr_arbiter_M #(
    parameter int unsigned M     = 4,
    parameter int unsigned SEL_W = $clog2(M)
) (
    input  logic [M-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned i = 1; i <= M; i++) begin
            idx = (32'(last) + i) % M;
            if (!grant_valid && req[SEL_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/multiplexer_n_mto1_reg.sv
// Registered M-channel, N-bit multiplexer with valid/ready handshake on every channel.
// Define MUX_RR_EN to compile in round-robin arbitration (mode input); otherwise fixed select only.
module multiplexer_n_mto1_reg
    import mux_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned M     = 4,
    parameter int unsigned SEL_W = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [M*N-1:0]   in_data,
    input  logic [M-1:0]     in_valid,
    output logic [M-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    output logic [N-1:0]     out_data,
    output logic [SEL_W-1:0] out_channel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load_en;
    logic             fix_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     sel_data;

    assign load_en = !out_valid || out_ready;

    // Fixed-mode grant; an out-of-range select matches no channel
    always_comb begin
        fix_valid = 1'b0;
        for (int unsigned k = 0; k < M; k++) begin
            if (select == SEL_W'(k) && in_valid[k]) begin
                fix_valid = 1'b1;
            end
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] last;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;

    rr_arbiter_M #(.M(M), .SEL_W(SEL_W)) u_rr_arbiter (
        .req         (in_valid),
        .last        (last),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    assign grant_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign grant_idx   = (mode == MODE_RR) ? rr_idx   : select;

    // Last-granted pointer advances on every transfer regardless of mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= SEL_W'(M - 1);
        end else if (load_en && grant_valid) begin
            last <= grant_idx;
        end
    end
`else
    logic mode_unused;

    assign mode_unused = (mode == MODE_RR);
    assign grant_valid = fix_valid;
    assign grant_idx   = select;
`endif

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data = in_data[k*N +: N];
            end
        end
    end

    // Reset forces the accept strobe low even though the empty output register would allow a load
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= {N{OUT_DATA_RST_BIT}};
            out_channel <= SEL_W'(OUT_CHANNEL_RST);
            out_valid   <= 1'b0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_data    <= sel_data;
                out_channel <= grant_idx;
                out_valid   <= 1'b1;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiplexer_n_mto1_reg.sv
// Directed self-checking bench for multiplexer_n_mto1_reg (N=10, M=4); RR tests need MUX_RR_EN.
module tb_multiplexer_n_mto1_reg;

    localparam int unsigned N     = 10;
    localparam int unsigned M     = 4;
    localparam int unsigned SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [M*N-1:0]   in_data;
    logic [M-1:0]     in_valid;
    logic [M-1:0]     in_ready;
    logic             mode;
    logic [SEL_W-1:0] select;
    logic [N-1:0]     out_data;
    logic [SEL_W-1:0] out_channel;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] ch_word [M];

    multiplexer_n_mto1_reg #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .select      (select),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic load_words();
        for (int k = 0; k < M; k++) in_data[k*N +: N] = ch_word[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; select = '0; in_valid = 4'b1111; out_ready = 1'b1;
        ch_word[0] = 10'h155; ch_word[1] = 10'h0F0; ch_word[2] = 10'h2AA; ch_word[3] = 10'h3C3;
        load_words();
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 10'd0) begin n_err++; $display("FAIL reset_out_data got %h want 000", out_data); end
        n_cmp++; if (out_channel !== 2'd0) begin n_err++; $display("FAIL reset_out_channel got %0d want 0", out_channel); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0000;
        #1;
    endtask

    task automatic test_fixed_grant();
        select = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        ch_word[2] = 10'b1001110011;
        load_words();
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_data !== 10'b1001110011) begin n_err++; $display("FAIL fixed_out_data got %b want 1001110011", out_data); end
        n_cmp++; if (out_channel !== 2'd2) begin n_err++; $display("FAIL fixed_out_channel got %0d want 2", out_channel); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_out_valid got %b want 1", out_valid); end
    endtask

    task automatic test_fixed_no_grant();
        select = 2'd1; in_valid = 4'b1101;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL nogrant_in_ready got %b want 0000", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nogrant_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 10'b1001110011) begin n_err++; $display("FAIL nogrant_out_data_hold got %b want 1001110011", out_data); end
        n_cmp++; if (out_channel !== 2'd2) begin n_err++; $display("FAIL nogrant_out_channel_hold got %0d want 2", out_channel); end
    endtask

    task automatic test_stall();
        ch_word[0] = 10'h155; ch_word[3] = 10'h3C3;
        load_words();
        select = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 10'h155) begin n_err++; $display("FAIL stall_preload got %h want 155", out_data); end
        out_ready = 1'b0; in_valid = 4'b1111; select = 2'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b want 0000", c, in_ready); end
            tick();
            select = 2'(c);
            n_cmp++; if (out_data !== 10'h155 || out_channel !== 2'd0 || out_valid !== 1'b1)
                begin n_err++; $display("FAIL stall_hold[%0d] got %h/%0d/%b want 155/0/1", c, out_data, out_channel, out_valid); end
        end
        select = 2'd3; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL stall_release_in_ready got %b want 1000", in_ready); end
        tick();
        n_cmp++; if (out_data !== 10'h3C3 || out_channel !== 2'd3 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL stall_release_load got %h/%0d/%b want 3c3/3/1", out_data, out_channel, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_word [4];
        exp_word[0] = 10'h155; exp_word[1] = 10'h0F0; exp_word[2] = 10'h2AA; exp_word[3] = 10'h3C3;
        ch_word[0] = 10'h155; ch_word[1] = 10'h0F0; ch_word[2] = 10'h2AA; ch_word[3] = 10'h3C3;
        load_words();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            select = 2'(c);
            tick();
            n_cmp++; if (out_data !== exp_word[c] || out_channel !== 2'(c) || out_valid !== 1'b1)
                begin n_err++; $display("FAIL b2b[%0d] got %h/%0d/%b want %h/%0d/1", c, out_data, out_channel, out_valid, exp_word[c], c); end
        end
    endtask

    task automatic test_reset_mid();
        select = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 10'd0 || out_channel !== 2'd0)
            begin n_err++; $display("FAIL midreset got %b/%h/%0d want 0/000/0", out_valid, out_data, out_channel); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL midreset_in_ready got %b want 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0000; out_ready = 1'b1;
        #1;
    endtask

`ifdef MUX_RR_EN
    task automatic test_round_robin();
        logic [SEL_W-1:0] seq_a [5];
        logic [SEL_W-1:0] seq_b [4];
        seq_a[0] = 2'd0; seq_a[1] = 2'd1; seq_a[2] = 2'd2; seq_a[3] = 2'd3; seq_a[4] = 2'd0;
        seq_b[0] = 2'd1; seq_b[1] = 2'd3; seq_b[2] = 2'd1; seq_b[3] = 2'd3;
        mode = 1'b1; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_first_in_ready got %b want 0001", in_ready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (out_channel !== seq_a[c] || out_valid !== 1'b1)
                begin n_err++; $display("FAIL rr_all[%0d] got ch %0d v %b want ch %0d v 1", c, out_channel, out_valid, seq_a[c]); end
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (out_channel !== seq_b[c] || out_data !== ch_word[seq_b[c]])
                begin n_err++; $display("FAIL rr_1010[%0d] got ch %0d data %h want ch %0d", c, out_channel, out_data, seq_b[c]); end
        end
    endtask
`else
    task automatic test_mode_ignored();
        mode = 1'b1; select = 2'd3; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL noRR_in_ready[%0d] got %b want 1000", c, in_ready); end
            tick();
            n_cmp++; if (out_channel !== 2'd3 || out_data !== 10'h3C3 || out_valid !== 1'b1)
                begin n_err++; $display("FAIL noRR_out[%0d] got %0d/%h/%b want 3/3c3/1", c, out_channel, out_data, out_valid); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_grant();
        test_fixed_no_grant();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX_RR_EN
        test_round_robin();
`else
        test_mode_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
